// File: rtl/skid_buf_64bit_pkg.sv
// Shared state encoding for the 64-bit skid buffer.
// Code 2'b11 is never entered; the top recovers from it to ST_EMPTY.
package skid_buf_64bit_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/reg_en_64bit.sv
// WIDTH-bit register with load enable.
// Asynchronous active-low reset clears the register to zero.
module reg_en_64bit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skid_buf_64bit.sv
// Two-entry valid/ready skid buffer with registered in_ready and out_valid.
// Optional output transfer counter enabled by macro SKID_BUF_64BIT_XFER_CNT_EN.
module skid_buf_64bit
  import skid_buf_64bit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SKID_BUF_64BIT_XFER_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  skid_state_e      state, state_nxt;
  logic             in_ready_q, out_valid_q;
  logic             in_fire, out_fire;
  logic             main_en, main_sel_skid, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;

  always_comb begin
    state_nxt     = state;
    main_en       = 1'b0;
    main_sel_skid = 1'b0;
    skid_en       = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          state_nxt = ST_BUSY;
          main_en   = 1'b1;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire && !out_ready) begin
          state_nxt = ST_FULL;
          skid_en   = 1'b1;
        end else if (!in_valid && out_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Input is blocked here; the skid word moves up as soon as main drains.
        if (out_ready) begin
          state_nxt     = ST_BUSY;
          main_en       = 1'b1;
          main_sel_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Handshake flops are loaded from the next state so both stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != ST_FULL);
      out_valid_q <= (state_nxt != ST_EMPTY);
    end
  end

  assign main_d = main_sel_skid ? skid_q : in_data;

  reg_en_64bit #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  reg_en_64bit #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

`ifdef SKID_BUF_64BIT_XFER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_fire) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end
`else
  logic [31:0] cnt_w_unused;
  assign cnt_w_unused = 32'(CNT_W);
`endif

endmodule
